// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD operand sequencer.
package gcd_pkg;

   localparam int GCD_W              = 16;
   localparam int GCD_CW             = 16;
   localparam int GCD_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      WAIT   = 3'd3,
      CLEAR  = 3'd4,
      RESP   = 3'd5
   } gcd_state_t;

endpackage

// File: rtl/gcd_operand_sequencer_if.sv
// Operand, engine and result bundle of the GCD operand sequencer.
interface gcd_operand_sequencer_if
   import gcd_pkg::*;
#(
   parameter int W  = GCD_W,
   parameter int CW = GCD_CW
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          gcd_start;
   logic [W-1:0]  gcd_data;
   logic          gcd_clr;
   logic          gcd_done;
   logic [W-1:0]  gcd_result;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic [CW-1:0] res_cycles;
   logic          res_err;

   modport slave (
      input  in_valid, in_a, in_b, gcd_done, gcd_result, res_ready,
      output in_ready, gcd_start, gcd_data, gcd_clr,
             res_valid, res_data, res_cycles, res_err
   );

   modport master (
      output in_valid, in_a, in_b, gcd_done, gcd_result, res_ready,
      input  in_ready, gcd_start, gcd_data, gcd_clr,
             res_valid, res_data, res_cycles, res_err
   );
endinterface

// File: rtl/gcd_sat_counter.sv
// CW-bit up-counter with synchronous clear and enable that holds at all-ones.
module gcd_sat_counter
   import gcd_pkg::*;
#(
   parameter int CW = GCD_CW
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_count
);
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && !(&r_count)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds (A,B) pairs to the subtractive GCD engine and returns its result.
// Optional watchdog in WAIT enabled by defining GCD_TIMEOUT_EN.
module gcd_operand_sequencer
   import gcd_pkg::*;
#(
   parameter int W              = GCD_W,
   parameter int CW             = GCD_CW,
   parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
)(
   input  logic                    clk,
   input  logic                    rst_n,
   gcd_operand_sequencer_if.slave  io_seq
);
`ifdef GCD_TIMEOUT_EN
   localparam bit WATCHDOG_EN = 1'b1;
`else
   localparam bit WATCHDOG_EN = 1'b0;
`endif

   gcd_state_t    r_state;
   gcd_state_t    w_state_next;
   logic [W-1:0]  r_op_b;
   logic [W-1:0]  r_gcd_data;
   logic [W-1:0]  r_res_data;
   logic [CW-1:0] r_res_cycles;
   logic [CW-1:0] w_wait_cnt;
   logic          w_zero_pair;
   logic          w_cnt_run;
   logic          w_timeout;

   assign w_zero_pair = (io_seq.in_a == '0) || (io_seq.in_b == '0);

   // Counter already runs in LOAD_B, so in WAIT it reads the current WAIT cycle number.
   assign w_cnt_run = (r_state == LOAD_B) || (r_state == WAIT);

   gcd_sat_counter #(
      .CW(CW)
   ) u_wait_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (!w_cnt_run),
      .i_en    (w_cnt_run),
      .o_count (w_wait_cnt)
   );

   // A done arriving on the same cycle as the limit wins over the watchdog.
   assign w_timeout = WATCHDOG_EN && (r_state == WAIT) && !io_seq.gcd_done &&
                      (32'(w_wait_cnt) >= 32'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (io_seq.in_valid) begin
               w_state_next = w_zero_pair ? RESP : LOAD_A;
            end
         end
         LOAD_A: w_state_next = LOAD_B;
         LOAD_B: w_state_next = WAIT;
         WAIT: begin
            if (io_seq.gcd_done || w_timeout) begin
               w_state_next = CLEAR;
            end
         end
         CLEAR: w_state_next = RESP;
         RESP: begin
            if (io_seq.res_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_b       <= '0;
         r_gcd_data   <= '0;
         r_res_data   <= '0;
         r_res_cycles <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_seq.in_valid) begin
                  r_op_b <= io_seq.in_b;
                  // gcd(0,x)=x and gcd(0,0)=0; the engine would never finish on these.
                  if (w_zero_pair) begin
                     r_res_data   <= io_seq.in_a | io_seq.in_b;
                     r_res_cycles <= '0;
                  end else begin
                     r_gcd_data   <= io_seq.in_a;
                  end
               end
            end
            LOAD_A: r_gcd_data <= r_op_b;
            WAIT: begin
               if (io_seq.gcd_done) begin
                  r_res_data   <= io_seq.gcd_result;
                  r_res_cycles <= w_wait_cnt;
               end else if (w_timeout) begin
                  r_res_data   <= '0;
                  r_res_cycles <= w_wait_cnt;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef GCD_TIMEOUT_EN
   logic r_res_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_err <= 1'b0;
      end else if (w_timeout) begin
         r_res_err <= 1'b1;
      end else if ((r_state == RESP) && io_seq.res_ready) begin
         r_res_err <= 1'b0;
      end
   end

   assign io_seq.res_err = r_res_err;
`else
   assign io_seq.res_err = 1'b0;
`endif

   assign io_seq.in_ready   = (r_state == IDLE);
   assign io_seq.gcd_start  = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign io_seq.gcd_data   = r_gcd_data;
   assign io_seq.gcd_clr    = (r_state == CLEAR);
   assign io_seq.res_valid  = (r_state == RESP);
   assign io_seq.res_data   = r_res_data;
   assign io_seq.res_cycles = r_res_cycles;
endmodule
